// File: rtl/flag_branch_unit.sv
// flag_branch_unit: NZCV flag register plus a one-request-per-cycle branch
// resolver for B.cond, CBZ and CBNZ. Each accepted request produces one
// decision (br_done/br_taken) in the following cycle. A saturating counter
// records how many branches were taken.
// Optional feature macro: FLAG_FWD_EN. When it is defined, a B.cond that
// arrives together with set_flags evaluates on the incoming flags. When it is
// undefined, such a request is stalled for one cycle.
// state_dbg exposes the IDLE/RESP state for observation.
//
// Handshake: a request transfers on a rising edge where br_valid && br_ready.
// The requester holds br_kind/br_cond stable while br_valid=1 and br_ready=0.
// br_done pulses for exactly one cycle per transferred request, and br_taken
// is meaningful only while br_done=1.
module flag_branch_unit #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_negative,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  input  logic             set_flags,
  input  logic             br_valid,
  input  logic [1:0]       br_kind,
  input  logic [3:0]       br_cond,
  output logic             br_ready,
  output logic             br_done,
  output logic             br_taken,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] taken_count,
  output logic             state_dbg
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t     state, state_next;
  logic       z_in;
  logic [3:0] flags_in;
  logic [3:0] eval_flags;
  logic       accept;
  logic       taken_next;
  logic       taken_r;

  assign z_in     = (alu_result == '0);
  assign flags_in = {alu_negative, z_in, alu_carry, alu_overflow};

`ifdef FLAG_FWD_EN
  assign br_ready   = reset;
  assign eval_flags = set_flags ? flags_in : flags;
`else
  // A flag update in flight blocks the request so that it sees registered flags.
  assign br_ready   = reset && !set_flags;
  assign eval_flags = flags;
`endif

  assign accept = br_valid && br_ready;

  // Evaluate an ARM condition code against an {N,Z,C,V} vector.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, gt;
    n  = f[3];
    z  = f[2];
    c  = f[1];
    v  = f[0];
    gt = !z && (n == v);
    case (cond)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = !z;
      4'b0010: cond_eval = c;
      4'b0011: cond_eval = !c;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = !n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = !v;
      4'b1000: cond_eval = c && !z;
      4'b1001: cond_eval = !(c && !z);
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = gt;
      4'b1101: cond_eval = !gt;
      default: cond_eval = 1'b1;  // AL and NV both branch unconditionally
    endcase
  endfunction

  // Decide the branch outcome for the request being accepted this cycle.
  always_comb begin
    taken_next = 1'b0;
    case (br_kind)
      2'b00:   taken_next = cond_eval(br_cond, eval_flags);
      2'b01:   taken_next = z_in;
      2'b10:   taken_next = !z_in;
      default: taken_next = 1'b0;  // reserved kind completes as not-taken
    endcase
  end

  // FSM state register; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: RESP follows every accept, and IDLE follows a cycle without one.
  always_comb begin
    state_next = IDLE;
    if (accept) state_next = RESP;
  end

  // Capture the decision alongside the state transition.
  always_ff @(posedge clk) begin
    if (!reset)      taken_r <= 1'b0;
    else if (accept) taken_r <= taken_next;
    else             taken_r <= 1'b0;
  end

  // Architectural flag register, written only by flag-setting ALU ops.
  always_ff @(posedge clk) begin
    if (!reset)         flags <= 4'b0000;
    else if (set_flags) flags <= flags_in;
  end

  // Reset gates the outputs directly, so a reset during RESP suppresses the decision.
  assign br_done   = reset && (state == RESP);
  assign br_taken  = br_done && taken_r;
  assign state_dbg = state;

  // Saturating count of taken decisions.
  always_ff @(posedge clk) begin
    if (!reset)
      taken_count <= '0;
    else if (br_done && br_taken && (taken_count != {CNT_W{1'b1}}))
      taken_count <= taken_count + 1'b1;
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed testbench for flag_branch_unit, built with CNT_W=2 so that counter
// saturation can be reached in a few cycles. It supports both FLAG_FWD_EN
// builds.
module tb_flag_branch_unit;

  logic        clk;
  logic        reset;
  logic [63:0] alu_result;
  logic        alu_negative;
  logic        alu_overflow;
  logic        alu_carry;
  logic        set_flags;
  logic        br_valid;
  logic [1:0]  br_kind;
  logic [3:0]  br_cond;
  logic        br_ready;
  logic        br_done;
  logic        br_taken;
  logic [3:0]  flags;
  logic [1:0]  taken_count;
  logic        state_dbg;

  int n_cmp;
  int n_fail;

  flag_branch_unit #(.WIDTH(64), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .alu_result(alu_result),
    .alu_negative(alu_negative), .alu_overflow(alu_overflow),
    .alu_carry(alu_carry), .set_flags(set_flags), .br_valid(br_valid),
    .br_kind(br_kind), .br_cond(br_cond), .br_ready(br_ready),
    .br_done(br_done), .br_taken(br_taken), .flags(flags),
    .taken_count(taken_count), .state_dbg(state_dbg)
  );

  // Clock and initial input state.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    set_flags    = 1'b0;
    br_valid     = 1'b0;
    br_kind      = 2'b00;
    br_cond      = 4'b0000;
    alu_result   = 64'h1;
    alu_negative = 1'b0;
    alu_overflow = 1'b0;
    alu_carry    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    step();
    step();
    reset = 1'b1;
    #1;
    n_cmp++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", flags); end
    n_cmp++; if (br_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", br_done); end
    n_cmp++; if (taken_count !== 2'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", taken_count); end
    n_cmp++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", br_ready); end
  endtask

  task automatic test_flags_eq();
    set_flags = 1'b1; alu_result = 64'h0; alu_carry = 1'b1;
    alu_negative = 1'b0; alu_overflow = 1'b0;
    step();
    set_flags = 1'b0; alu_result = 64'h1; alu_carry = 1'b0;
    n_cmp++; if (flags !== 4'b0110) begin n_fail++; $display("FAIL flags_set got=%b exp=0110", flags); end
    br_valid = 1'b1; br_kind = 2'b00; br_cond = 4'b0000;   // EQ
    step();
    br_cond = 4'b0001;                                     // NE
    n_cmp++; if (br_done !== 1'b1 || br_taken !== 1'b1) begin n_fail++; $display("FAIL eq done=%b taken=%b exp=1/1", br_done, br_taken); end
    step();
    br_valid = 1'b0;
    n_cmp++; if (br_done !== 1'b1 || br_taken !== 1'b0) begin n_fail++; $display("FAIL ne done=%b taken=%b exp=1/0", br_done, br_taken); end
    step();
    n_cmp++; if (br_done !== 1'b0 || br_taken !== 1'b0) begin n_fail++; $display("FAIL idle done=%b taken=%b exp=0/0", br_done, br_taken); end
  endtask

  // Flags are 0110 (Z=1, C=1, N=0, V=0) at this point.
  task automatic test_cond_table();
    logic [3:0] conds [8];
    logic       exp_t [8];
    conds = '{4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101, 4'b1111, 4'b0010, 4'b0101};
    exp_t = '{1'b0,    1'b1,    1'b1,    1'b0,    1'b1,    1'b1,    1'b1,    1'b1};
    br_valid = 1'b1; br_kind = 2'b00;
    for (int i = 0; i < 8; i++) begin
      br_cond = conds[i];
      step();
      n_cmp++;
      if (br_done !== 1'b1 || br_taken !== exp_t[i]) begin
        n_fail++;
        $display("FAIL cond_%b done=%b taken=%b exp=1/%b", conds[i], br_done, br_taken, exp_t[i]);
      end
    end
    br_valid = 1'b0;
    step();
  endtask

  task automatic test_forwarding();
    set_flags = 1'b1; alu_negative = 1'b1; alu_overflow = 1'b0;
    alu_carry = 1'b0; alu_result = 64'h5;
    br_valid = 1'b1; br_kind = 2'b00; br_cond = 4'b1011;   // LT
    #1;
`ifdef FLAG_FWD_EN
    n_cmp++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_ready got=%b exp=1", br_ready); end
    step();
    idle_inputs();
    n_cmp++; if (br_done !== 1'b1 || br_taken !== 1'b1) begin n_fail++; $display("FAIL fwd_lt done=%b taken=%b exp=1/1", br_done, br_taken); end
    n_cmp++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL fwd_flags got=%b exp=1000", flags); end
`else
    n_cmp++; if (br_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got=%b exp=0", br_ready); end
    step();
    set_flags = 1'b0;
    n_cmp++; if (br_done !== 1'b0) begin n_fail++; $display("FAIL stall_done got=%b exp=0", br_done); end
    n_cmp++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL stall_flags got=%b exp=1000", flags); end
    #1;
    n_cmp++; if (br_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready2 got=%b exp=1", br_ready); end
    step();
    idle_inputs();
    n_cmp++; if (br_done !== 1'b1 || br_taken !== 1'b1) begin n_fail++; $display("FAIL stall_lt done=%b taken=%b exp=1/1", br_done, br_taken); end
`endif
    step();
  endtask

  // Flags are 1000 at this point.
  task automatic test_cbz_cbnz();
    br_valid = 1'b1; br_kind = 2'b01; alu_result = 64'h0;
    step();
    br_kind = 2'b10; alu_result = 64'h1;
    n_cmp++; if (br_done !== 1'b1 || br_taken !== 1'b1) begin n_fail++; $display("FAIL cbz done=%b taken=%b exp=1/1", br_done, br_taken); end
    step();
    br_kind = 2'b01; alu_result = 64'h8000_0000_0000_0000;  // only the top bit set: not zero
    n_cmp++; if (br_done !== 1'b1 || br_taken !== 1'b1) begin n_fail++; $display("FAIL cbnz done=%b taken=%b exp=1/1", br_done, br_taken); end
    step();
    br_kind = 2'b11; br_cond = 4'b1110;
    n_cmp++; if (br_done !== 1'b1 || br_taken !== 1'b0) begin n_fail++; $display("FAIL cbz_msb done=%b taken=%b exp=1/0", br_done, br_taken); end
    step();
    idle_inputs();
    n_cmp++; if (br_done !== 1'b1 || br_taken !== 1'b0) begin n_fail++; $display("FAIL reserved done=%b taken=%b exp=1/0", br_done, br_taken); end
    n_cmp++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL cb_flags got=%b exp=1000", flags); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_cnt;
    reset = 1'b0;
    step();
    reset = 1'b1;
    br_valid = 1'b1; br_kind = 2'b00; br_cond = 4'b1110;   // AL
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 4) br_valid = 1'b0;
      exp_cnt = (i > 3) ? 2'd3 : 2'(i);
      n_cmp++;
      if (br_done !== 1'b1 || br_taken !== 1'b1 || taken_count !== exp_cnt) begin
        n_fail++;
        $display("FAIL b2b_%0d done=%b taken=%b cnt=%0d exp=1/1/%0d", i, br_done, br_taken, taken_count, exp_cnt);
      end
    end
    step();
    n_cmp++; if (br_done !== 1'b0 || taken_count !== 2'd3) begin n_fail++; $display("FAIL b2b_end done=%b cnt=%0d exp=0/3", br_done, taken_count); end
    step();
    n_cmp++; if (taken_count !== 2'd3) begin n_fail++; $display("FAIL b2b_hold cnt=%0d exp=3", taken_count); end
  endtask

  task automatic test_reset_cancel();
    br_valid = 1'b1; br_kind = 2'b00; br_cond = 4'b1100;   // GT on flags 0000 is taken
    step();
    idle_inputs();
    reset = 1'b0;
    #1;
    n_cmp++; if (br_done !== 1'b0) begin n_fail++; $display("FAIL cancel_now done=%b exp=0", br_done); end
    step();
    n_cmp++; if (br_done !== 1'b0 || flags !== 4'b0000) begin n_fail++; $display("FAIL cancel_after done=%b flags=%b exp=0/0000", br_done, flags); end
    reset = 1'b1;
    step();
    n_cmp++; if (br_done !== 1'b0 || state_dbg !== 1'b0) begin n_fail++; $display("FAIL cancel_idle done=%b state=%b exp=0/0", br_done, state_dbg); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_flags_eq();
    test_cond_table();
    test_forwarding();
    test_cbz_cbnz();
    test_back_to_back();
    test_reset_cancel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
